counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_if.sv | 31 +++
 rtl/counter_reset_sync.sv | 23 ++
 rtl/counter.sv | 63 ++++++
 tb/tb_counter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared constants and elaboration helpers for the counter block.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package counter_pkg;

    // Default count width and terminal count used by the counter and its interface.
    localparam int COUNTER_WIDTH = 4;
    localparam int COUNTER_MAX   = 15;

    // True when max_value is representable as an unsigned number of width bits.
    // Widths of 31 and above always hold any non-negative int, which also keeps
    // the shift inside the int range.
    function automatic bit counter_fits(input int max_value, input int width);
        if (width >= 31) begin
            return 1'b1;
        end
        return (max_value < (1 << width));
    endfunction

endpackage

// File: rtl/counter_if.sv
// Counter bus: enable in, count/terminal-count/wrap out.
// Latency: n/a (wires only).
// Backpressure: none; enable alone gates counting.
interface counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
);

    logic             enable;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    // The side that drives enable and observes the counter.
    modport master (
        output enable,
        input  count,
        input  tc,
        input  wrap
    );

    // The counter itself.
    modport slave (
        input  enable,
        output count,
        output tc,
        output wrap
    );

endinterface

// File: rtl/counter_reset_sync.sv
// Reset synchroniser: asynchronous assert, 2-flop synchronous deassert, active-low.
// Latency: release seen on the 2nd rising clk edge after i_rst_n goes high; assert is immediate.
// Backpressure: none.
module reset_sync (
    input  logic clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic [1:0] r_sync;

    // Clear both stages at once on reset; shift a one through on release.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign o_rst_n = r_sync[1];

endmodule

// File: rtl/counter.sv
// Up-counter 0..MAX_VALUE with registered one-cycle wrap pulse and combinational terminal count.
// Latency: count/wrap update on the clk edge that samples enable; tc follows enable in the same cycle.
// Backpressure: none; enable low holds the count and suppresses wrap.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = COUNTER_WIDTH,
    parameter int MAX_VALUE = COUNTER_MAX
)(
    input  logic     clk,
    input  logic     reset,
    counter_if.slave bus
);

    // Reject parameter sets the counter cannot represent.
    if (WIDTH < 1 || MAX_VALUE < 1 || !counter_fits(MAX_VALUE, WIDTH)) begin : g_bad_params
        $error("counter: illegal WIDTH/MAX_VALUE combination");
    end

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic             w_rst_n;
    logic             w_at_max;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    // Internal reset asserts immediately and releases two edges after the pin rises.
    reset_sync u_reset_sync (
        .clk     (clk),
        .i_rst_n (reset),
        .o_rst_n (w_rst_n)
    );

    assign w_at_max = (r_count == MAX_CNT);

    // Count register: advance while enabled, fold back to zero after the terminal value.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_count <= '0;
        end else if (bus.enable) begin
            if (w_at_max) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + ONE;
            end
        end
    end

    // Wrap pulse: high only for the cycle after an enabled edge at the terminal value.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= bus.enable && w_at_max;
        end
    end

    assign bus.count = r_count;
    assign bus.wrap  = r_wrap;
    assign bus.tc    = w_at_max && bus.enable;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: default instance (0..15) and a MAX_VALUE=9 instance.
// Latency: checks one time unit after each rising edge; asynchronous reset checked between edges.
// Backpressure: n/a.
module tb_counter;
    import counter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: counts as plain integers modulo (max+1), edges since reset release.
    int m_cnt_a  = 0;
    int m_cnt_b  = 0;
    int m_wrap_a = 0;
    int m_wrap_b = 0;
    int m_age    = 0;

    localparam int MAX_A = 15;
    localparam int MAX_B = 9;

    always #5 clk = ~clk;

    counter_if #(.WIDTH(4)) bus_a ();
    counter_if #(.WIDTH(4)) bus_b ();

    counter #(.WIDTH(4), .MAX_VALUE(MAX_A)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    counter #(.WIDTH(4), .MAX_VALUE(MAX_B)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_cnt_a"},  int'(bus_a.count), m_cnt_a);
        chk({tag, "_wrap_a"}, int'(bus_a.wrap),  m_wrap_a);
        chk({tag, "_tc_a"},   int'(bus_a.tc),    int'(m_cnt_a == MAX_A && bus_a.enable));
        chk({tag, "_cnt_b"},  int'(bus_b.count), m_cnt_b);
        chk({tag, "_wrap_b"}, int'(bus_b.wrap),  m_wrap_b);
        chk({tag, "_tc_b"},   int'(bus_b.tc),    int'(m_cnt_b == MAX_B && bus_b.enable));
    endtask

    // One clock edge: the model decides from the inputs present before the edge.
    task automatic tick(input string tag);
        int na, nb, wa, wb;
        na = m_cnt_a; nb = m_cnt_b; wa = 0; wb = 0;
        if (!reset) begin
            na = 0; nb = 0;
        end else if (m_age >= 2) begin
            if (bus_a.enable) begin
                wa = int'(m_cnt_a == MAX_A);
                na = (m_cnt_a + 1) % (MAX_A + 1);
            end
            if (bus_b.enable) begin
                wb = int'(m_cnt_b == MAX_B);
                nb = (m_cnt_b + 1) % (MAX_B + 1);
            end
        end
        @(posedge clk);
        #1;
        m_cnt_a = na; m_cnt_b = nb; m_wrap_a = wa; m_wrap_b = wb;
        if (reset && m_age < 2) m_age++;
        chk_all(tag);
    endtask

    task automatic set_en(input logic a, input logic b);
        bus_a.enable = a;
        bus_b.enable = b;
        #1;
        chk("tc_now_a", int'(bus_a.tc), int'(m_cnt_a == MAX_A && a));
        chk("tc_now_b", int'(bus_b.tc), int'(m_cnt_b == MAX_B && b));
    endtask

    // Reset pulse placed between edges; called right after tick (edge + 1).
    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #1;
        m_cnt_a = 0; m_cnt_b = 0; m_wrap_a = 0; m_wrap_b = 0; m_age = 0;
        chk_all("async_rst");
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int guard;
        bus_a.enable = 1'b1;
        bus_b.enable = 1'b1;
        #1;
        chk_all("reset_state");
        tick("in_reset");
        tick("in_reset");
        #6;
        reset = 1'b1;             // t = 22
        tick("sync1");
        chk("hold_edge1", int'(bus_a.count), 0);
        tick("sync2");
        chk("hold_edge2", int'(bus_a.count), 0);
        tick("first_inc");
        chk("first_inc_val", int'(bus_a.count), 1);

        // Free run across several wraps of both instances.
        for (int i = 0; i < 36; i++) tick("run");

        // Hold at 7 with enable low, then resume.
        guard = 0;
        while (m_cnt_a != 7 && guard < 20) begin tick("to7"); guard++; end
        chk("reach7", int'(bus_a.count), 7);
        set_en(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick("hold");
        chk("held7", int'(bus_a.count), 7);
        set_en(1'b1, 1'b1);
        tick("resume");
        chk("after_hold", int'(bus_a.count), 8);

        // Reset mid-count at 9.
        guard = 0;
        while (m_cnt_a != 9 && guard < 20) begin tick("to9"); guard++; end
        chk("reach9", int'(bus_a.count), 9);
        pulse_reset();
        tick("rs1");
        tick("rs2");
        tick("rs3");
        chk("resume_after_rst", int'(bus_a.count), 1);

        // Alternating enable from zero.
        pulse_reset();
        tick("az1");
        tick("az2");
        for (int i = 0; i < 10; i++) begin
            set_en(i[0] == 1'b0, i[0] == 1'b0);
            tick("alt");
        end
        chk("alt_total", int'(bus_a.count), 5);

        // Random enables with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            set_en(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            tick("rand");
            if ($urandom_range(0, 49) == 0) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got t=%0t, expected < 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
